serial_grid_evaluator: RTL and testbench
========================================

SERIAL_GRID_EVALUATOR -- requirements
Module: serial_grid_evaluator

Interface
REQ-001 SHALL have parameter ROW, default 4: grid rows, range 1..16.
REQ-002 SHALL have parameter COL, default 4: grid columns, range 1..16.
REQ-003 SHALL have parameter IN, default 4: primary circuit inputs, range 1..8.
REQ-004 SHALL have parameter OUT, default 2: circuit outputs, range 1..8.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port cfg_valid, input, 1: serial genome bit present.
REQ-008 SHALL have port cfg_bit, input, 1: serial genome data.
REQ-009 SHALL have port cfg_full, output, 1: exactly G bits shifted since last commit.
REQ-010 SHALL have port target, input, OUT*2^IN: expected truth table; bit v*OUT+k = output k for input vector v.
REQ-011 SHALL have port start, input, 1: commit genome and begin evaluation.
REQ-012 SHALL have port busy, output, 1: evaluation in progress.
REQ-013 SHALL have port done, output, 1: one-cycle pulse, fitness valid.
REQ-014 SHALL have port fitness, output, clog2(OUT*2^IN+1): count of matching truth-table bits.

Function
REQ-015 Genome width G = ROW*COL*16 + OUT*SW, SW = clog2(ROW*COL) (minimum 1); SHALL be shifted LSB-side in, MSB-first, one bit per cycle with cfg_valid high, into a shadow register.
REQ-016 Shadow layout: bits [16*(i*COL+j) +: 16] = LUT of cell (i,j); above that, OUT selectors of SW bits, selector k at lowest index k.
REQ-017 Shift counter SHALL saturate at G; cfg_full = (count == G); shifting beyond G continues to shift, counter stays at G.
REQ-018 Shifting SHALL be accepted in every state, including during evaluation (double-buffered; active genome unaffected).
REQ-019 Each cell SHALL be a 4-input LUT: index bit0 = west, bit1 = north, bit2 = north-west, bit3 = inp[(i*COL+j) % IN]; out = LUT[index].
REQ-020 Missing neighbours at grid edge SHALL be replaced by inp[(i+j) % IN]; grid is strictly acyclic (no east/south feeds).
REQ-021 Output k SHALL be cell (s/COL, s%COL), s = selector k; s >= ROW*COL yields 0.
REQ-022 FSM states IDLE, EVAL, DONE; IDLE->EVAL on start; EVAL->DONE after last vector compared; DONE->IDLE next cycle.
REQ-023 start in IDLE or DONE SHALL copy shadow to active genome, latch target, clear counter to 0 and clear fitness; start in EVAL SHALL be ignored.
REQ-024 EVAL SHALL apply vector v = 0..2^IN-1, one per cycle; each cycle fitness += popcount(~(out ^ target[v*OUT +: OUT])).
REQ-025 done SHALL assert for one cycle (DONE state) exactly 2^IN+1 cycles after the start cycle; busy high in EVAL only.
REQ-026 fitness SHALL hold its final value until the next accepted start.
REQ-027 Simultaneous start and cfg_valid SHALL commit the shadow contents before that cycle's shift.

Reset
REQ-028 rst SHALL return FSM to IDLE and clear shadow, active genome, shift count, latched target, fitness, busy, done, cfg_full to 0.
REQ-029 rst mid-EVAL SHALL abort without a done pulse; rst has priority over start and cfg_valid.

Configuration
REQ-030 Macro GRID_PIPE_EN defined: grid outputs SHALL be registered before comparison; start-to-done latency becomes 2^IN+2; comparison uses target of the registered vector.
REQ-031 Macro GRID_PIPE_EN undefined: comparison combinational from grid, latency per REQ-025.

Structure
REQ-032 Shared package SHALL hold the FSM state enum, LUT width constant 16, and functions for G, SW, fitness width.
REQ-033 The combinational grid SHALL be sub-module lut_grid (params ROW, COL, IN, OUT; ports genome, inp, out).

Verification
REQ-034 ROW=COL=2, IN=2, OUT=1; all LUTs 16'hAAAA, selector 0, target 4'b1010 -> done after 5 cycles, fitness 4.
REQ-035 Same genome, target 4'b0101 -> fitness 0; all LUTs 16'h0000, target 4'b0000 -> fitness 4.
REQ-036 Shift 10 bits then check cfg_full=0; shift to G -> cfg_full=1; shift 3 more -> still 1, count unchanged.
REQ-037 Start, new genome shifted during EVAL, second start mid-EVAL -> second start ignored; result reflects first genome; next start uses new genome.
REQ-038 Assert rst in cycle 2 of EVAL -> no done, fitness 0, busy 0 next cycle.
REQ-039 Repeat REQ-034 with GRID_PIPE_EN -> done after 6 cycles, fitness 4.

Source files
------------

// File: rtl/serial_grid_evaluator_pkg.sv
// Shared definitions for the serial grid evaluator: FSM states, LUT width and
// helpers deriving genome, selector and fitness widths from the grid parameters.
package serial_grid_evaluator_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EVAL = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int LUT_W = 16;

   // Selector width; a single-cell grid still needs one selector bit.
   function automatic int calc_sw(input int rows, input int cols);
      int s;
      s = $clog2(rows * cols);
      return (s < 1) ? 1 : s;
   endfunction

   function automatic int calc_g(input int rows, input int cols, input int outs);
      return rows * cols * LUT_W + outs * calc_sw(rows, cols);
   endfunction

   function automatic int calc_fit_w(input int ins, input int outs);
      return $clog2(outs * (2 ** ins) + 1);
   endfunction

endpackage

// File: rtl/serial_grid_evaluator_lut_grid.sv
// Combinational ROW x COL grid of 4-input LUT cells fed from west, north and
// north-west neighbours, plus per-output cell selectors taken from the genome.
module lut_grid
   import serial_grid_evaluator_pkg::*;
#(
   parameter  int ROW = 4,
   parameter  int COL = 4,
   parameter  int IN  = 4,
   parameter  int OUT = 2,
   localparam int SW  = calc_sw(ROW, COL),
   localparam int G   = calc_g(ROW, COL, OUT)
) (
   input  logic [G-1:0]   genome,
   input  logic [IN-1:0]  inp,
   output logic [OUT-1:0] out
);

   always_comb begin
      logic [ROW*COL-1:0] w_cells;
      logic               w_edge;
      logic               w_west;
      logic               w_north;
      logic               w_nw;
      logic [3:0]         w_idx;
      logic [SW-1:0]      w_sel;
      // NOTE: every variable gets a default first so no path through the block infers a latch.
      w_cells = '0;
      w_edge  = 1'b0;
      w_west  = 1'b0;
      w_north = 1'b0;
      w_nw    = 1'b0;
      w_idx   = '0;
      w_sel   = '0;
      out     = '0;

      // Row-major order guarantees every neighbour is resolved before it is read.
      for (int i = 0; i < ROW; i++) begin
         for (int j = 0; j < COL; j++) begin
            w_edge  = inp[(i + j) % IN];
            w_west  = (j > 0) ? w_cells[i*COL + j - 1] : w_edge;
            w_north = (i > 0) ? w_cells[(i-1)*COL + j] : w_edge;
            w_nw    = (i > 0 && j > 0) ? w_cells[(i-1)*COL + j - 1] : w_edge;
            w_idx   = {inp[(i*COL + j) % IN], w_nw, w_north, w_west};
            w_cells[i*COL + j] = genome[LUT_W*(i*COL + j) + int'(w_idx)];
         end
      end

      for (int k = 0; k < OUT; k++) begin
         w_sel = genome[ROW*COL*LUT_W + k*SW +: SW];
         if (int'(w_sel) < ROW*COL) out[k] = w_cells[w_sel];
      end
   end

endmodule

// File: rtl/serial_grid_evaluator.sv
// Serially configured LUT-grid circuit scored against a target truth table.
// Define GRID_PIPE_EN to register grid outputs before comparison (+1 cycle latency).
module serial_grid_evaluator
   import serial_grid_evaluator_pkg::*;
#(
   parameter  int ROW = 4,
   parameter  int COL = 4,
   parameter  int IN  = 4,
   parameter  int OUT = 2,
   localparam int G   = calc_g(ROW, COL, OUT),
   localparam int NV  = 2 ** IN,
   localparam int TW  = OUT * NV,
   localparam int FW  = calc_fit_w(IN, OUT)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_valid,
   input  logic          cfg_bit,
   output logic          cfg_full,
   input  logic [TW-1:0] target,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [FW-1:0] fitness
);

   localparam int            CW       = $clog2(G + 1);
   localparam logic [IN-1:0] LAST_VEC = IN'(NV - 1);

   state_t         r_state;
   logic [G-1:0]   r_shadow;
   logic [G-1:0]   r_active;
   logic [CW-1:0]  r_count;
   logic [TW-1:0]  r_target;
   logic [FW-1:0]  r_fitness;
   logic [IN-1:0]  r_vec;
   logic           r_busy;
   logic           r_done;

   logic [OUT-1:0] w_grid_out;
   logic [OUT-1:0] w_cmp_out;
   logic [IN-1:0]  w_cmp_vec;
   logic           w_cmp_valid;
   logic           w_cmp_last;
   logic [FW-1:0]  w_match;
   logic           w_start_ok;

   lut_grid #(.ROW(ROW), .COL(COL), .IN(IN), .OUT(OUT)) u_grid (
      .genome (r_active),
      .inp    (r_vec),
      .out    (w_grid_out)
   );

`ifdef GRID_PIPE_EN
   logic           r_issue;
   logic           r_pvalid;
   logic [IN-1:0]  r_pvec;
   logic [OUT-1:0] r_pout;

   assign w_cmp_valid = r_pvalid;
   assign w_cmp_vec   = r_pvec;
   assign w_cmp_out   = r_pout;
`else
   assign w_cmp_valid = (r_state == ST_EVAL);
   assign w_cmp_vec   = r_vec;
   assign w_cmp_out   = w_grid_out;
`endif

   assign w_cmp_last = w_cmp_valid && (w_cmp_vec == LAST_VEC);
   assign w_match    = FW'($countones(~(w_cmp_out ^ r_target[w_cmp_vec*OUT +: OUT])));
   assign w_start_ok = start && (r_state != ST_EVAL);

   assign cfg_full = (r_count == CW'(G));
   assign busy     = r_busy;
   assign done     = r_done;
   assign fitness  = r_fitness;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_shadow <= '0;
         r_count  <= '0;
      end else begin
         // NOTE: non-blocking assignments make every flop sample pre-edge values, so a
         // start in the same cycle as a shift commits the shadow as it was before that shift.
         if (cfg_valid) r_shadow <= {r_shadow[G-2:0], cfg_bit};
         if (w_start_ok)                            r_count <= cfg_valid ? CW'(1) : '0;
         else if (cfg_valid && r_count != CW'(G))   r_count <= r_count + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_active  <= '0;
         r_target  <= '0;
         r_fitness <= '0;
         r_vec     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
`ifdef GRID_PIPE_EN
         r_issue   <= 1'b0;
         r_pvalid  <= 1'b0;
         r_pvec    <= '0;
         r_pout    <= '0;
`endif
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_active  <= r_shadow;
                  r_target  <= target;
                  r_fitness <= '0;
                  r_vec     <= '0;
                  r_busy    <= 1'b1;
                  r_state   <= ST_EVAL;
`ifdef GRID_PIPE_EN
                  r_issue   <= 1'b1;
                  r_pvalid  <= 1'b0;
`endif
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_EVAL: begin
               if (w_cmp_valid) r_fitness <= r_fitness + w_match;
               if (w_cmp_last) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
               end
`ifdef GRID_PIPE_EN
               r_pvalid <= r_issue;
               r_pvec   <= r_vec;
               r_pout   <= w_grid_out;
               if (r_issue) begin
                  if (r_vec == LAST_VEC) r_issue <= 1'b0;
                  else                   r_vec   <= r_vec + IN'(1);
               end
`else
               r_vec <= r_vec + IN'(1);
`endif
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_grid_evaluator.sv
// Self-checking bench for serial_grid_evaluator on a 2x2 grid, 2 inputs, 1 output;
// latency expectation follows GRID_PIPE_EN.
module tb_serial_grid_evaluator;

   localparam int ROW = 2;
   localparam int COL = 2;
   localparam int IN  = 2;
   localparam int OUT = 1;
   localparam int SW  = 2;
   localparam int G   = ROW*COL*16 + OUT*SW;
   localparam int NV  = 1 << IN;
   localparam int TW  = OUT * NV;
   localparam int FW  = $clog2(TW + 1);
`ifdef GRID_PIPE_EN
   localparam int LAT = NV + 2;
`else
   localparam int LAT = NV + 1;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_valid;
   logic          cfg_bit;
   logic          cfg_full;
   logic [TW-1:0] target;
   logic          start;
   logic          busy;
   logic          done;
   logic [FW-1:0] fitness;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_grid_evaluator #(.ROW(ROW), .COL(COL), .IN(IN), .OUT(OUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_valid (cfg_valid),
      .cfg_bit   (cfg_bit),
      .cfg_full  (cfg_full),
      .target    (target),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .fitness   (fitness)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic shift_bits(input logic [G-1:0] g, input int hi, input int lo);
      for (int i = hi; i >= lo; i--) begin
         cfg_valid = 1'b1;
         cfg_bit   = g[i];
         tick();
      end
      cfg_valid = 1'b0;
   endtask

   // Reference: evaluates the whole truth table directly from the cell rules.
   function automatic int model_fitness(input logic [G-1:0] g, input logic [TW-1:0] t);
      int fit;
      int c[ROW][COL];
      int b[IN];
      int e, w, n, nw, idx, s, o;
      fit = 0;
      for (int v = 0; v < NV; v++) begin
         for (int q = 0; q < IN; q++) b[q] = (v >> q) & 1;
         for (int i = 0; i < ROW; i++) begin
            for (int j = 0; j < COL; j++) begin
               e  = b[(i + j) % IN];
               w  = e;
               n  = e;
               nw = e;
               if (j > 0) w = c[i][j-1];
               if (i > 0) n = c[i-1][j];
               if (i > 0 && j > 0) nw = c[i-1][j-1];
               idx = w + 2*n + 4*nw + 8*b[(i*COL + j) % IN];
               c[i][j] = int'(g[16*(i*COL + j) + idx]);
            end
         end
         for (int k = 0; k < OUT; k++) begin
            s = 0;
            for (int q = 0; q < SW; q++) s += int'(g[ROW*COL*16 + k*SW + q]) << q;
            o = 0;
            if (s < ROW*COL) o = c[s / COL][s % COL];
            if (o == int'(t[v*OUT + k])) fit++;
         end
      end
      return fit;
   endfunction

   task automatic run(input logic [TW-1:0] tgt, input int exp_fit, input string tag,
                      input logic with_shift);
      int cyc;
      target    = tgt;
      start     = 1'b1;
      cfg_valid = with_shift;
      cfg_bit   = 1'b1;
      tick();
      start     = 1'b0;
      cfg_valid = 1'b0;
      check({tag, "_busy"}, 64'(busy), 64'(1));
      cyc = 1;
      while (!done && cyc < LAT + 4) begin
         tick();
         cyc++;
      end
      check({tag, "_latency"}, 64'(cyc), 64'(LAT));
      check({tag, "_fitness"}, 64'(fitness), 64'(exp_fit));
      check({tag, "_busy_at_done"}, 64'(busy), 64'(0));
      tick();
      check({tag, "_done_pulse"}, 64'(done), 64'(0));
      check({tag, "_hold"}, 64'(fitness), 64'(exp_fit));
   endtask

   initial begin
      logic [G-1:0]  g_a;
      logic [G-1:0]  g_b;
      logic [G-1:0]  g_r;
      logic [TW-1:0] t_r;
      int            n_done;
      int            d_cyc;
      int            d_fit;
      logic          seen;

      rst       = 1'b1;
      cfg_valid = 1'b0;
      cfg_bit   = 1'b0;
      start     = 1'b0;
      target    = '0;
      tick();
      tick();
      check("rst_cfg_full", 64'(cfg_full), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_fitness", 64'(fitness), 64'(0));
      rst = 1'b0;

      g_a = '0;
      for (int c = 0; c < ROW*COL; c++) g_a[16*c +: 16] = 16'hAAAA;
      g_b = '0;

      // Shift counter boundaries
      shift_bits(g_a, G-1, G-10);
      check("full_after_10", 64'(cfg_full), 64'(0));
      shift_bits(g_a, G-11, 1);
      check("full_at_g_minus_1", 64'(cfg_full), 64'(0));
      shift_bits(g_a, 0, 0);
      check("full_at_g", 64'(cfg_full), 64'(1));
      shift_bits(g_b, 2, 0);
      check("full_saturated", 64'(cfg_full), 64'(1));
      shift_bits(g_a, G-1, 0);

      run(4'b1010, 4, "aaaa_1010", 1'b0);
      check("full_cleared_by_start", 64'(cfg_full), 64'(0));
      run(4'b0101, 0, "aaaa_0101", 1'b0);
      shift_bits(g_b, G-1, 0);
      run(4'b0000, 4, "zero_0000", 1'b0);

      // Shift during evaluation, with an ignored start mid-EVAL
      shift_bits(g_a, G-1, 0);
      target = 4'b1010;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      seen   = 1'b0;
      n_done = 0;
      d_cyc  = 0;
      d_fit  = 0;
      for (int i = 0; i < G; i++) begin
         cfg_valid = 1'b1;
         cfg_bit   = g_b[G-1-i];
         start     = (i == 1);
         tick();
         if (done) begin
            n_done++;
            if (!seen) begin
               seen  = 1'b1;
               d_cyc = i + 2;
               d_fit = int'(fitness);
            end
         end
      end
      cfg_valid = 1'b0;
      start     = 1'b0;
      check("mid_latency", 64'(d_cyc), 64'(LAT));
      check("mid_fitness_first_genome", 64'(d_fit), 64'(4));
      check("mid_single_done", 64'(n_done), 64'(1));
      run(4'b0000, 4, "after_mid_new_genome", 1'b0);

      // Commit precedes same-cycle shift
      shift_bits(g_a, G-1, 0);
      run(4'b1010, 4, "start_with_shift", 1'b1);

      // Reset in cycle 2 of EVAL
      target = 4'b0000;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_done", 64'(done), 64'(0));
      check("abort_fitness", 64'(fitness), 64'(0));
      n_done = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done) n_done++;
      end
      check("abort_no_done", 64'(n_done), 64'(0));

      // Randomized genomes and targets against the reference model
      for (int r = 0; r < 8; r++) begin
         g_r = G'({$urandom(), $urandom(), $urandom()});
         t_r = TW'($urandom());
         shift_bits(g_r, G-1, 0);
         run(t_r, model_fitness(g_r, t_r), $sformatf("rand%0d", r), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
